// File: rtl/hs_ram_bridge.sv
// hs_ram_bridge: lends the single-port work RAM to the hiscore engine while the CPU is paused.
// Optional out-of-window write statistics on err_count: define HS_RAM_BRIDGE_STATS_EN.
module hs_ram_bridge #(
   parameter logic [15:0] RAM_BASE     = 16'h6000,
   parameter int          RAM_AW       = 12,
   parameter int          QUIET_CYCLES = 4
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              pause_cpu,
   input  logic              hs_access,
   input  logic              hs_write,
   input  logic [15:0]       hs_address,
   input  logic [7:0]        hs_data_in,
   output logic [7:0]        hs_data_out,
   output logic              hs_owned,
   input  logic [RAM_AW-1:0] cpu_addr,
   input  logic [7:0]        cpu_din,
   input  logic              cpu_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [7:0]        ram_din,
   output logic              ram_we,
   input  logic [7:0]        ram_dout,
   output logic [7:0]        err_count
);

   typedef enum logic [1:0] {
      ST_CPU,
      ST_DRAIN,
      ST_HS,
      ST_RELEASE
   } state_t;

   localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYCLES - 1);

   state_t     state_q, state_d;
   logic [7:0] quiet_q, quiet_d;
   logic       rd_v1_q, rd_v1_d;
   logic       rd_w1_q, rd_w1_d;
   logic [7:0] dout_q, dout_d;
   logic       in_win;
   logic       hs_live;

   assign in_win  = (hs_address[15:RAM_AW] == RAM_BASE[15:RAM_AW]);
   assign hs_live = hs_access && pause_cpu;

   always_comb begin
      state_d = state_q;
      quiet_d = quiet_q;
      case (state_q)
         ST_CPU: begin
            if (hs_live) begin
               state_d = ST_DRAIN;
               quiet_d = 8'h00;
            end
         end
         ST_DRAIN: begin
            if (!hs_live) begin
               state_d = ST_CPU;
            end else if (cpu_we) begin
               quiet_d = 8'h00;
            end else if (quiet_q == QUIET_LAST) begin
               state_d = ST_HS;
            end else begin
               quiet_d = quiet_q + 8'd1;
            end
         end
         ST_HS: begin
            if (!hs_live) begin
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            state_d = ST_CPU;
         end
         default: begin
            state_d = ST_CPU;
         end
      endcase
   end

   // During reset the port always behaves as in CPU, whatever state_q holds.
   always_comb begin
      ram_addr = cpu_addr;
      ram_din  = cpu_din;
      ram_we   = cpu_we;
      if (!reset) begin
         case (state_q)
            ST_HS: begin
               ram_addr = hs_address[RAM_AW-1:0];
               ram_din  = hs_data_in;
               ram_we   = hs_write && in_win && pause_cpu;
            end
            ST_RELEASE: begin
               ram_we = 1'b0;
            end
            default: begin
               ram_we = cpu_we;
            end
         endcase
      end
   end

   always_comb begin
      rd_v1_d = (state_q == ST_HS);
      rd_w1_d = in_win;
      dout_d  = dout_q;
      if (rd_v1_q) begin
         dout_d = rd_w1_q ? ram_dout : 8'hFF;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= ST_CPU;
         quiet_q <= 8'h00;
         rd_v1_q <= 1'b0;
         rd_w1_q <= 1'b0;
         dout_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         quiet_q <= quiet_d;
         rd_v1_q <= rd_v1_d;
         rd_w1_q <= rd_w1_d;
         dout_q  <= dout_d;
      end
   end

   assign hs_owned    = (state_q == ST_HS);
   assign hs_data_out = dout_q;

`ifdef HS_RAM_BRIDGE_STATS_EN
   logic [7:0] err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (state_q == ST_HS && hs_write && !in_win && err_q != 8'hFF) begin
         err_d = err_q + 8'd1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         err_q <= 8'h00;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_count = err_q;
`else
   assign err_count = 8'h00;
`endif

endmodule
